// File: rtl/sample_pkg.sv
// Shared constants and types for the sample main pipeline and its wrappers.
package sample_pkg;

  localparam int unsigned SAMPLE_DATA_W       = 32;
  localparam int unsigned SAMPLE_PIPE_LATENCY = 2;

  typedef logic [SAMPLE_DATA_W-1:0] sample_word_t;

endpackage : sample_pkg

// File: rtl/sample_fifo_fwft.sv
// First-word fall-through result FIFO; any DEPTH >= 1, not only powers of two.
// Ports:
//   clk, rst  - clock and synchronous active-high reset
//   wr_en     - write request; dropped when full unless a read frees the slot
//   wr_data   - word to write
//   rd_en     - read request; ignored when empty
//   rd_data   - head word (valid only while !empty)
//   count     - number of stored words
//   full      - count == DEPTH
//   empty     - count == 0
module sample_fifo_fwft
  import sample_pkg::*;
#(
  parameter int unsigned DATA_W = SAMPLE_DATA_W,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic [CW-1:0]     count,
  output logic              full,
  output logic              empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              wr_ok;
  logic              rd_ok;

  // Explicit wrap at DEPTH-1 so non-power-of-two depths work.
  function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign rd_ok   = rd_en && !empty;
  // A read in the same cycle frees the slot, so a write at full is still taken.
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr];

  // Storage array has no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (!rst && wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers and count.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= bump(wr_ptr);
      if (rd_ok) rd_ptr <= bump(rd_ptr);
      count <= count + CW'(wr_ok) - CW'(rd_ok);
    end
  end

endmodule : sample_fifo_fwft

// File: rtl/sample_main_credit_adapter.sv
// Credit-based ready/valid wrapper around the fixed-latency sample main pipeline.
// Issue is gated on credits (in_flight + FIFO count < DEPTH); every pipeline
// result is caught in a FWFT FIFO and drained under out_ready.
// Ports:
//   clk, rst           - clock and synchronous active-high reset (shared with pipeline)
//   in_valid/in_ready  - producer handshake; issue = in_valid & in_ready
//   pipe_input_valid   - to pipeline input_valid
//   pipe_output_valid  - from pipeline output_valid
//   pipe_out           - from pipeline result
//   out_valid/out_ready- consumer handshake; pop = out_valid & out_ready
//   out_data           - FIFO head
//   occupancy          - in_flight + FIFO count
//   err                - sticky overflow / in_flight underflow flag
module sample_main_credit_adapter
  import sample_pkg::*;
#(
  parameter int unsigned DATA_W       = SAMPLE_DATA_W,
  parameter int unsigned PIPE_LATENCY = SAMPLE_PIPE_LATENCY,
  parameter int unsigned DEPTH        = 4,
  localparam int unsigned CW          = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              pipe_input_valid,
  input  logic              pipe_output_valid,
  input  logic [DATA_W-1:0] pipe_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CW-1:0]     occupancy,
  output logic              err
);

  if (DEPTH < 1 || PIPE_LATENCY < 1) begin : g_param_check
    $error("sample_main_credit_adapter: DEPTH and PIPE_LATENCY must be >= 1");
  end

  logic [CW-1:0] in_flight;
  logic [CW-1:0] count;
  logic [CW:0]   credits_used;
  logic          full;
  logic          empty;
  logic          issue;
  logic          pop;
  logic          dec;
  logic          overflow;
  logic          underflow;

  // One extra bit so an error-inflated sum cannot wrap below DEPTH.
  assign credits_used     = {1'b0, in_flight} + {1'b0, count};
  assign occupancy        = CW'(credits_used);

  // Credit check uses registers only: a pop frees its credit next cycle.
  assign in_ready         = !rst && (credits_used < (CW + 1)'(DEPTH));
  assign issue            = in_valid && in_ready;
  assign pipe_input_valid = issue;

  assign out_valid        = !rst && !empty;
  assign pop              = out_valid && out_ready;

  assign underflow        = pipe_output_valid && (in_flight == '0);
  assign overflow         = pipe_output_valid && full && !pop;
  assign dec              = pipe_output_valid && !underflow;

  // In-flight counter and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_flight <= '0;
      err       <= 1'b0;
    end else begin
      in_flight <= in_flight + CW'(issue) - CW'(dec);
      if (overflow || underflow) err <= 1'b1;
    end
  end

  sample_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (pipe_output_valid),
    .wr_data (pipe_out),
    .rd_en   (pop),
    .rd_data (out_data),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

endmodule : sample_main_credit_adapter

// File: tb/tb_sample_main_credit_adapter.sv
// Bench: two adapters (DEPTH 4 and DEPTH 3), each behind a 2-cycle pipeline
// model, checked against a token-level model of credits and result timing.
module tb_sample_main_credit_adapter;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       in_valid;
  logic [1:0]       in_ready;
  logic [1:0]       piv;
  logic [1:0]       pov;
  logic [1:0]       force_pov;
  logic [1:0][31:0] pipe_out;
  logic [1:0]       out_valid;
  logic [1:0]       out_ready;
  logic [1:0][31:0] out_data;
  logic [1:0][2:0]  occ;
  logic [1:0]       err;
  logic [1:0][31:0] word;

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    localparam int unsigned D = (k == 0) ? 4 : 3;
    logic [1:0]              pv;
    logic [31:0]             pd0;
    logic [31:0]             pd1;
    logic [$clog2(D+1)-1:0]  occ_l;

    // External pipeline: 2-cycle valid/data delay line.
    always @(posedge clk) begin
      if (rst) pv <= 2'b00;
      else     pv <= {pv[0], piv[k]};
      pd0 <= word[k];
      pd1 <= pd0;
    end
    assign pov[k]      = pv[1] | force_pov[k];
    assign pipe_out[k] = pd1;
    assign occ[k]      = 3'(occ_l);

    sample_main_credit_adapter #(
      .DATA_W       (32),
      .PIPE_LATENCY (2),
      .DEPTH        (D)
    ) u_dut (
      .clk               (clk),
      .rst               (rst),
      .in_valid          (in_valid[k]),
      .in_ready          (in_ready[k]),
      .pipe_input_valid  (piv[k]),
      .pipe_output_valid (pov[k]),
      .pipe_out          (pipe_out[k]),
      .out_valid         (out_valid[k]),
      .out_ready         (out_ready[k]),
      .out_data          (out_data[k]),
      .occupancy         (occ_l),
      .err               (err[k])
    );
  end

  typedef struct {
    int          t;
    logic [31:0] w;
  } ent_t;

  ent_t q[$];
  int   outst;
  int   cyc;
  int   n_issued;
  int   n_total;
  int   n_pass;
  int   n_fail;

  function automatic int dep(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    outst    = 0;
    cyc      = 0;
    n_issued = 0;
  endtask

  // One cycle on DUT k: drive, check at negedge against the token model, advance.
  task automatic step(input int k, input logic iv, input logic ordy, input logic [31:0] w);
    logic er;
    logic eov;
    ent_t tmp;
    in_valid[k]  = iv;
    out_ready[k] = ordy;
    word[k]      = w;
    @(negedge clk);
    er  = (outst < dep(k));
    eov = (q.size() > 0) && (q[0].t + 3 <= cyc);
    chk("in_ready", 32'(in_ready[k]), 32'(er));
    chk("pipe_input_valid", 32'(piv[k]), 32'(iv & er));
    chk("out_valid", 32'(out_valid[k]), 32'(eov));
    if (eov) chk("out_data", out_data[k], q[0].w);
    chk("occupancy", 32'(occ[k]), 32'(outst));
    chk("err", 32'(err[k]), 32'd0);
    if (iv && er) begin
      q.push_back('{cyc, w});
      outst++;
      n_issued++;
    end
    if (eov && ordy) begin
      tmp = q.pop_front();
      outst--;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total   = 0;
    n_pass    = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 2'b11;
    out_ready = 2'b00;
    force_pov = 2'b00;
    word      = '0;
    model_clear();

    // Reset held 3 cycles with in_valid high.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready", 32'(in_ready[0]), 32'd0);
      chk("rst_piv", 32'(piv[0]), 32'd0);
      chk("rst_out_valid", 32'(out_valid[0]), 32'd0);
      if (i > 0) chk("rst_err", 32'(err[0]), 32'd0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 2'b00;

    // Single op returning 0x2a; out_valid at t+3, occupancy back to 0 at t+4.
    step(0, 1'b1, 1'b1, 32'h0000_002a);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1, 32'h0);

    // Backpressure: four issues then stall, release after.
    model_clear();
    for (int i = 0; i < 8; i++) step(0, 1'b1, 1'b0, $urandom);
    chk("bp_issues", 32'(n_issued), 32'd4);
    for (int i = 0; i < 10; i++) step(0, 1'b1, 1'b1, $urandom);
    for (int i = 0; i < 6; i++) step(0, 1'b0, 1'b1, 32'h0);

    // Streaming: 20 back-to-back issues.
    model_clear();
    for (int i = 0; i < 20; i++) step(0, 1'b1, 1'b1, $urandom);
    chk("stream_issues", 32'(n_issued), 32'd20);
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1, 32'h0);

    // Random traffic on the DEPTH=3 instance.
    model_clear();
    for (int c = 0; c < 3000 && n_issued < 200; c++) begin
      step(1, 1'(($urandom % 4) != 0), 1'($urandom % 2), $urandom);
    end
    chk("rand_issue_budget", 32'(n_issued), 32'd200);
    for (int i = 0; i < 12; i++) step(1, 1'b0, 1'b1, 32'h0);
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Underflow: pipeline output with nothing in flight.
    in_valid  = 2'b00;
    out_ready = 2'b00;
    force_pov = 2'b01;
    @(negedge clk);
    chk("uf_err_before", 32'(err[0]), 32'd0);
    @(posedge clk);
    #1;
    force_pov = 2'b00;
    @(negedge clk);
    chk("uf_err_set", 32'(err[0]), 32'd1);
    chk("uf_written", 32'(out_valid[0]), 32'd1);
    chk("uf_occupancy", 32'(occ[0]), 32'd1);
    @(posedge clk);
    #1;
    chk("uf_err_sticky", 32'(err[0]), 32'd1);

    // Reset clears the error.
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst1_err", 32'(err[0]), 32'd0);
    chk("rst1_occ", 32'(occ[0]), 32'd0);
    chk("rst1_out_valid", 32'(out_valid[0]), 32'd0);
    @(posedge clk);
    #1;

    // Mid-operation reset with occupancy 3.
    model_clear();
    for (int i = 0; i < 3; i++) step(0, 1'b1, 1'b0, $urandom);
    step(0, 1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 32'(in_ready[0]), 32'd0);
    chk("mid_rst_out_valid", 32'(out_valid[0]), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_occ", 32'(occ[0]), 32'd0);
    chk("mid_rst_err", 32'(err[0]), 32'd0);
    chk("mid_rst_in_ready_after", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    // Discarded in-flight work must never surface.
    model_clear();
    for (int i = 0; i < 5; i++) step(0, 1'b0, 1'b1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_sample_main_credit_adapter
